cl_mult_sched: RTL

Round-robin scheduler that shares one pipelined carry-less/integer array multiplier between two requesters. It arbitrates operand requests, drives the multiplier's operand, mode and enable ports, and tracks every in-flight operation with a tag pipeline. When the fixed-latency product emerges, it routes it back to the requester that issued it. It sits between the field-arithmetic units (inversion and reduction sequencers) and the shared multiplier instance.

---
 rtl/cl_mult_sched.sv | 113 +++++++++++
 1 files changed

// File: rtl/cl_mult_sched.sv
// Round-robin scheduler sharing one fixed-latency multiplier between two requesters.
// A tag pipeline tracks each issued operation so its product is returned to its issuer.
module cl_mult_sched #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned MULT_LATENCY = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req0_valid,
  output logic                      req0_ready,
  input  logic [DATA_WIDTH-1:0]     req0_a,
  input  logic [DATA_WIDTH-1:0]     req0_b,
  input  logic                      req0_carry,
  input  logic                      req1_valid,
  output logic                      req1_ready,
  input  logic [DATA_WIDTH-1:0]     req1_a,
  input  logic [DATA_WIDTH-1:0]     req1_b,
  input  logic                      req1_carry,
  output logic                      resp0_valid,
  output logic [2*DATA_WIDTH-1:0]   resp0_data,
  output logic                      resp1_valid,
  output logic [2*DATA_WIDTH-1:0]   resp1_data,
  output logic                      mult_enable,
  output logic [DATA_WIDTH-1:0]     mult_a,
  output logic [DATA_WIDTH-1:0]     mult_b,
  output logic                      mult_carry_option,
  input  logic [2*DATA_WIDTH-1:0]   mult_result,
  output logic [3:0]                in_flight,
  output logic                      idle
);

  logic                    prio;
  logic [MULT_LATENCY-1:0] tag_valid;
  logic [MULT_LATENCY-1:0] tag_port;
  logic                    can_grant;
  logic                    grant0;
  logic                    grant1;
  logic                    grant_any;
  logic                    resp_fire;
  logic                    resp_port;

  // The multiplier clears its registers while enable is low, so hold off grants until it is up.
  assign can_grant = mult_enable & ~rst;
  assign grant0    = can_grant & req0_valid & (~req1_valid | ~prio);
  assign grant1    = can_grant & req1_valid & (~req0_valid | prio);
  assign grant_any = grant0 | grant1;

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  assign resp_fire = tag_valid[MULT_LATENCY-1];
  assign resp_port = tag_port[MULT_LATENCY-1];

  always_comb begin
    mult_a            = '0;
    mult_b            = '0;
    mult_carry_option = 1'b0;
    if (grant0) begin
      mult_a            = req0_a;
      mult_b            = req0_b;
      mult_carry_option = req0_carry;
    end else if (grant1) begin
      mult_a            = req1_a;
      mult_b            = req1_b;
      mult_carry_option = req1_carry;
    end
  end

  always_comb begin
    resp0_valid = 1'b0;
    resp1_valid = 1'b0;
    resp0_data  = '0;
    resp1_data  = '0;
    if (resp_fire) begin
      if (resp_port) begin
        resp1_valid = 1'b1;
        resp1_data  = mult_result;
      end else begin
        resp0_valid = 1'b1;
        resp0_data  = mult_result;
      end
    end
  end

  assign idle = (in_flight == 4'd0) & ~req0_valid & ~req1_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      prio        <= 1'b0;
      tag_valid   <= '0;
      tag_port    <= '0;
      in_flight   <= 4'd0;
      mult_enable <= 1'b0;
    end else begin
      mult_enable <= 1'b1;
      if (grant_any) begin
        prio <= grant0;
      end
      tag_valid[0] <= grant_any;
      tag_port[0]  <= grant1;
      for (int unsigned i = 1; i < MULT_LATENCY; i++) begin
        tag_valid[i] <= tag_valid[i-1];
        tag_port[i]  <= tag_port[i-1];
      end
      case ({grant_any, resp_fire})
        2'b10:   in_flight <= in_flight + 4'd1;
        2'b01:   in_flight <= in_flight - 4'd1;
        default: in_flight <= in_flight;
      endcase
    end
  end

endmodule
